// File: rtl/packed_trace_buffer.sv
// Circular trace memory for packed N-lane vectors, drained oldest-first over valid/ready.
// Each lane keeps its own storage column and output register; the top holds the pointers and control.

module packed_trace_lane #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  ld_en,
    input  logic [AW-1:0]         ld_addr,
    output logic [DATA_WIDTH-1:0] q
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset)      q <= '0;
        else if (ld_en) q <= mem[ld_addr];
    end
endmodule

module packed_trace_buffer #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           tracing,
    input  logic                           valid_in,
    input  logic [N-1:0][DATA_WIDTH-1:0]   vector_in,
    input  logic                           drain_start,
    input  logic                           out_ready,
    output logic [N-1:0][DATA_WIDTH-1:0]   vector_out,
    output logic                           valid_out,
    output logic                           drain_done,
    output logic [$clog2(DEPTH):0]         occupancy,
    output logic                           wrapped
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [0:0] CAPTURE = 1'b0;
    localparam logic [0:0] DRAIN   = 1'b1;
    localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE    = (AW+1)'(1);

    logic [0:0]    state;
    logic [AW-1:0] wr_ptr, rd_ptr, ld_addr;
    logic [AW:0]   remaining;
    logic          wr_en, xfer, ld_en;

    always_comb begin
        wr_en   = (state == CAPTURE) && tracing && valid_in;
        xfer    = valid_out && out_ready;
        // First DRAIN cycle fetches the oldest entry; later fetches run one ahead of rd_ptr.
        ld_en   = (state == DRAIN) && (!valid_out || (xfer && remaining > ONE));
        ld_addr = valid_out ? rd_ptr + AW'(1) : rd_ptr;
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        packed_trace_lane #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AW(AW)) u_lane (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (wr_en),
            .wr_addr (wr_ptr),
            .wr_data (vector_in[g]),
            .ld_en   (ld_en),
            .ld_addr (ld_addr),
            .q       (vector_out[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CAPTURE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            remaining  <= '0;
            occupancy  <= '0;
            wrapped    <= 1'b0;
            valid_out  <= 1'b0;
            drain_done <= 1'b0;
        end else begin
            drain_done <= 1'b0;
            if (state == CAPTURE) begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + AW'(1);
                    if (occupancy == FULL) wrapped   <= 1'b1;
                    else                   occupancy <= occupancy + ONE;
                end else if (drain_start && !tracing) begin
                    if (occupancy == '0) begin
                        drain_done <= 1'b1;
                    end else begin
                        state     <= DRAIN;
                        rd_ptr    <= wr_ptr - occupancy[AW-1:0];
                        remaining <= occupancy;
                    end
                end
            end else begin
                if (!valid_out) begin
                    valid_out <= 1'b1;
                end else if (xfer) begin
                    remaining <= remaining - ONE;
                    if (remaining == ONE) begin
                        valid_out  <= 1'b0;
                        drain_done <= 1'b1;
                        state      <= CAPTURE;
                        occupancy  <= '0;
                        wrapped    <= 1'b0;
                        wr_ptr     <= '0;
                        rd_ptr     <= '0;
                    end else begin
                        rd_ptr <= rd_ptr + AW'(1);
                    end
                end
            end
        end
    end
endmodule
